punc_control: RTL and testbench

- Multi-cycle control FSM for the PUnC LC3 processor; sits directly upstream of the PUnC datapath and drives every datapath select, enable and load.
- Consumes the datapath's instruction register and n/z/p condition flags.
- Sequences fetch, decode, execute (plus a second execute cycle for indirect ops) and halt.
- All outputs are a pure function of current state and inputs (Moore on state, decoded from ir/nzp); next state is registered.

---
 rtl/punc_control.sv | 213 +++++++++++++++++++++
 tb/tb_punc_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control.sv
// rtl/punc_control.sv - PUnC LC3 multi-cycle control FSM
// Fetch/decode/execute sequencing; control outputs decoded from state, ir and n/z/p.
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADDI = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_ANDI = 3'd3;
    localparam logic [2:0] ALU_NOT  = 3'd4;

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic       imm_mode;
    logic       br_taken;
    logic       unused_ir;

    assign opcode    = ir[15:12];
    assign imm_mode  = ir[5];
    assign br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign unused_ir = ^{ir[8:6], ir[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (opcode == OP_LDI || opcode == OP_STI) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset overrides the state decode so an aborted instruction never writes.
    always_comb begin
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 2'd0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_w_addr_sel    = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        halted           = 1'b0;

        if (rst) begin
            pc_clr = 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_r_addr_sel = 2'd0;
                    ir_ld          = 1'b1;
                    pc_inc         = 1'b1;
                end

                S_DECODE: begin
                end

                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            rf_r0_addr_sel   = 1'b0;
                            rf_r1_addr_sel   = 1'b0;
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd0;
                            rf_w_addr_sel    = 1'b0;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b0;
                            if (opcode == OP_ADD) begin
                                alu_sel = imm_mode ? ALU_ADDI : ALU_ADD;
                            end else if (opcode == OP_AND) begin
                                alu_sel = imm_mode ? ALU_ANDI : ALU_AND;
                            end else begin
                                alu_sel = ALU_NOT;
                            end
                        end
                        OP_BR: begin
                            pc_ld          = br_taken;
                            pc_ld_data_sel = 2'd0;
                        end
                        OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                            rf_r0_addr_sel = 1'b0;
                        end
                        OP_JSR: begin
                            // PC already holds the return address, so R7 and PC update together.
                            rf_w_en        = 1'b1;
                            rf_w_addr_sel  = 1'b1;
                            rf_w_data_sel  = 2'd2;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        OP_LD, OP_LDR: begin
                            mem_r_addr_sel   = (opcode == OP_LDR) ? 2'd2 : 2'd1;
                            rf_r0_addr_sel   = 1'b0;
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_LEA: begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd3;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            mem_w_en       = 1'b1;
                            mem_w_addr_sel = (opcode == OP_STR) ? 2'd1 : 2'd0;
                            mem_w_data_sel = 1'b0;
                            rf_r0_addr_sel = 1'b0;
                            rf_r1_addr_sel = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            mem_r_addr_sel = 2'd1;
                        end
                        default: begin
                        end
                    endcase
                end

                S_EXEC2: begin
                    if (opcode == OP_LDI) begin
                        mem_r_addr_sel   = 2'd3;
                        rf_w_en          = 1'b1;
                        rf_w_data_sel    = 2'd1;
                        cond_ld          = 1'b1;
                        cond_ld_data_sel = 1'b1;
                    end else if (opcode == OP_STI) begin
                        mem_w_en       = 1'b1;
                        mem_w_addr_sel = 2'd2;
                        mem_w_data_sel = 1'b0;
                        rf_r1_addr_sel = 1'b1;
                    end
                end

                S_HALT: begin
                    halted = 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// tb/tb_punc_control.sv - randomized self-checking bench for punc_control
// Expected controls come from a per-phase instruction table model.
module tb_punc_control;

    typedef struct packed {
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       halted;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_w_en, mem_w_data_sel, rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
    logic        rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, cond_ld, cond_ld_data_sel, halted;
    logic [1:0]  mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic [2:0]  alu_sel;
    ctrl_t       dut_c;

    int checks = 0;
    int failures = 0;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel), .mem_w_data_sel(mem_w_data_sel),
        .mem_r_addr_sel(mem_r_addr_sel), .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
        .pc_ld_data_sel(pc_ld_data_sel), .alu_sel(alu_sel), .cond_ld(cond_ld),
        .cond_ld_data_sel(cond_ld_data_sel), .halted(halted)
    );

    always #5 clk = ~clk;

    assign dut_c = '{mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel, rf_w_en,
                     rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel, ir_ld,
                     pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel, cond_ld,
                     cond_ld_data_sel, halted};

    task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%07h expected=%07h", tag, got, exp);
        end
    endtask

    // Phase: 0 fetch, 1 decode, 2 execute, 3 second execute, 4 halted.
    function automatic ctrl_t model(input int phase, input logic [15:0] i,
                                    input logic nn, input logic zz, input logic pp);
        ctrl_t c;
        logic [3:0] op;
        c  = '0;
        op = i[15:12];
        if (phase == 0) begin
            c.ir_ld  = 1'b1;
            c.pc_inc = 1'b1;
        end else if (phase == 4) begin
            c.halted = 1'b1;
        end else if (phase == 2) begin
            if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
                c.rf_w_en = 1'b1;
                c.cond_ld = 1'b1;
                c.alu_sel = (op == 4'h9) ? 3'd4 : ((op == 4'h5) ? 3'd2 : 3'd0) + {2'b0, i[5]};
            end else if (op == 4'h0) begin
                c.pc_ld = (i[11] && nn) || (i[10] && zz) || (i[9] && pp);
            end else if (op == 4'hC) begin
                c.pc_ld = 1'b1;
                c.pc_ld_data_sel = 2'd1;
            end else if (op == 4'h4) begin
                c.rf_w_en = 1'b1;
                c.rf_w_addr_sel = 1'b1;
                c.rf_w_data_sel = 2'd2;
                c.pc_ld = 1'b1;
                c.pc_ld_data_sel = i[11] ? 2'd2 : 2'd1;
            end else if (op == 4'h2 || op == 4'h6 || op == 4'hE) begin
                c.rf_w_en = 1'b1;
                c.cond_ld = 1'b1;
                c.cond_ld_data_sel = 1'b1;
                c.rf_w_data_sel = (op == 4'hE) ? 2'd3 : 2'd1;
                c.mem_r_addr_sel = (op == 4'h2) ? 2'd1 : (op == 4'h6) ? 2'd2 : 2'd0;
            end else if (op == 4'h3 || op == 4'h7) begin
                c.mem_w_en = 1'b1;
                c.mem_w_addr_sel = (op == 4'h7) ? 2'd1 : 2'd0;
                c.rf_r1_addr_sel = 1'b1;
            end else if (op == 4'hA || op == 4'hB) begin
                c.mem_r_addr_sel = 2'd1;
            end
        end else if (phase == 3) begin
            if (op == 4'hA) begin
                c.mem_r_addr_sel = 2'd3;
                c.rf_w_en = 1'b1;
                c.rf_w_data_sel = 2'd1;
                c.cond_ld = 1'b1;
                c.cond_ld_data_sel = 1'b1;
            end else begin
                c.mem_w_en = 1'b1;
                c.mem_w_addr_sel = 2'd2;
                c.rf_r1_addr_sel = 1'b1;
            end
        end
        return c;
    endfunction

    task automatic run_instr(input logic [15:0] i, input logic [2:0] nzp, input bit rnd);
        int nph;
        ctrl_t exp;
        nph = (i[15:12] == 4'hA || i[15:12] == 4'hB) ? 4 : (i[15:12] == 4'hF) ? 2 : 3;
        for (int ph = 0; ph < nph; ph++) begin
            @(negedge clk);
            ir = i;
            {n, z, p} = rnd ? 3'($urandom) : nzp;
            #1;
            exp = model(ph, i, n, z, p);
            check_eq($sformatf("ir%04h_ph%0d", i, ph), dut_c, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        ctrl_t exp;
        exp = '0;
        exp.pc_clr = 1'b1;
        #1;
        check_eq(tag, dut_c, exp);
    endtask

    initial begin
        logic [15:0] ri;
        rst = 1'b1;
        ir  = 16'h0000;
        {n, z, p} = 3'b000;

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_reset($sformatf("reset_%0d", k));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("first_fetch", dut_c, model(0, ir, n, z, p));
        @(negedge clk);
        ir = 16'h1283;
        #1;
        check_eq("first_decode", dut_c, model(1, ir, n, z, p));
        @(negedge clk);
        #1;
        check_eq("first_exec_add", dut_c, model(2, ir, n, z, p));

        run_instr(16'h12A5, 3'b000, 1'b0);
        run_instr(16'h5283, 3'b000, 1'b0);
        run_instr(16'h52A5, 3'b000, 1'b0);
        run_instr(16'h927F, 3'b000, 1'b0);
        run_instr(16'h0402, 3'b010, 1'b0);
        run_instr(16'h0402, 3'b100, 1'b0);
        run_instr(16'h0000, 3'b111, 1'b0);
        run_instr(16'h0E00, 3'b001, 1'b0);
        run_instr(16'hA203, 3'b000, 1'b0);
        run_instr(16'hB203, 3'b000, 1'b0);
        run_instr(16'h4805, 3'b000, 1'b0);
        run_instr(16'h4080, 3'b000, 1'b0);
        run_instr(16'hC1C0, 3'b000, 1'b0);
        run_instr(16'h2203, 3'b000, 1'b0);
        run_instr(16'h6283, 3'b000, 1'b0);
        run_instr(16'hE203, 3'b000, 1'b0);
        run_instr(16'h3203, 3'b000, 1'b0);
        run_instr(16'h7283, 3'b000, 1'b0);
        run_instr(16'h8000, 3'b000, 1'b0);
        run_instr(16'hD000, 3'b000, 1'b0);

        for (int k = 0; k < 300; k++) begin
            ri = 16'($urandom);
            if (ri[15:12] == 4'hF) ri[15:12] = 4'h0;
            run_instr(ri, 3'b000, 1'b1);
        end

        // Reset in the middle of a store must suppress the write.
        run_instr(16'h3203, 3'b000, 1'b0);
        @(negedge clk);
        ir = 16'h3203;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_reset("rst_in_st_exec");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("fetch_after_abort", dut_c, model(0, ir, n, z, p));
        @(negedge clk);
        ir = 16'h1283;
        #1;
        check_eq("decode_after_abort", dut_c, model(1, ir, n, z, p));
        @(negedge clk);
        #1;
        check_eq("exec_after_abort", dut_c, model(2, ir, n, z, p));

        run_instr(16'hF025, 3'b000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ir = 16'($urandom);
            {n, z, p} = 3'($urandom);
            #1;
            check_eq($sformatf("halt_%0d", k), dut_c, model(4, ir, n, z, p));
        end
        @(negedge clk);
        rst = 1'b1;
        check_reset("rst_in_halt");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("fetch_after_halt", dut_c, model(0, ir, n, z, p));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
